// File: rtl/fifo_pkg.sv
// Shared helpers for fifo_flagged: width derivation and the parameter-legality check.
// The check macro expands to an if-generate that stops elaboration on illegal parameters.
package fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 32'sd0;
        v = value - 32'sd1;
        while (v > 32'sd0) begin
            result = result + 32'sd1;
            v = v >>> 32'sd1;
        end
        return result;
    endfunction

    function automatic int ptr_width(input int depth);
        return clog2(depth);
    endfunction

    // One extra bit so the count can represent DEPTH itself.
    function automatic int cnt_width(input int depth);
        return clog2(depth) + 32'sd1;
    endfunction

endpackage

`define FIFO_PARAM_CHECK(D, AF, AE) \
    if (((D) < 32'sd2) || ((((D) - 32'sd1) & (D)) != 32'sd0) || \
        ((AF) < 32'sd1) || ((AF) > (D)) || ((AE) < 32'sd0) || ((AE) >= (AF))) begin : g_bad_params \
        $error("fifo_flagged: illegal DEPTH/AF_LEVEL/AE_LEVEL combination"); \
    end

// File: rtl/fifo_mem.sv
// Storage for fifo_flagged: one synchronous write port, one asynchronous read port.
// Kept separate so a vendor RAM can replace it without touching the control logic.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port; storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end else begin
            mem_r[waddr] <= mem_r[waddr];
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/fifo_flagged.sv
// Single-clock first-word-fall-through FIFO with count, threshold flags and flush.
// Define FIFO_ERR_STICKY_EN to enable the sticky overflow/underflow flags.
module fifo_flagged
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = 3,
    parameter int AE_LEVEL = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    output logic                         full,
    output logic                         almost_full,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         empty,
    output logic                         almost_empty,
    output logic [cnt_width(DEPTH)-1:0]  count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

    `FIFO_PARAM_CHECK(DEPTH, AF_LEVEL, AE_LEVEL)

    logic [PW-1:0] rptr_r, wptr_r, rptr_nxt_s, wptr_nxt_s;
    logic [CW-1:0] count_r, count_nxt_s;
    logic          pop_ok_s, push_ok_s, mem_we_s;

    // All flags derive from the registered count only; there is no push lookahead.
    assign empty        = (count_r == CNT_ZERO);
    assign full         = (count_r == CNT_FULL);
    assign almost_full  = (count_r >= CNT_AF);
    assign almost_empty = (count_r <= CNT_AE);
    assign count        = count_r;

    // A push into a full FIFO is accepted when the head is popped in the same cycle.
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);
    assign mem_we_s  = push_ok_s & ~flush;

    // Next-state for pointers and occupancy; flush dominates everything.
    always_comb begin
        rptr_nxt_s  = rptr_r;
        wptr_nxt_s  = wptr_r;
        count_nxt_s = count_r;
        if (flush) begin
            rptr_nxt_s  = PTR_ZERO;
            wptr_nxt_s  = PTR_ZERO;
            count_nxt_s = CNT_ZERO;
        end else begin
            if (push_ok_s) begin
                wptr_nxt_s = wptr_r + PTR_ONE;
            end else begin
                wptr_nxt_s = wptr_r;
            end
            if (pop_ok_s) begin
                rptr_nxt_s = rptr_r + PTR_ONE;
            end else begin
                rptr_nxt_s = rptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_nxt_s = count_r + CNT_ONE;
                2'b01:   count_nxt_s = count_r - CNT_ONE;
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_r  <= PTR_ZERO;
            wptr_r  <= PTR_ZERO;
            count_r <= CNT_ZERO;
        end else begin
            rptr_r  <= rptr_nxt_s;
            wptr_r  <= wptr_nxt_s;
            count_r <= count_nxt_s;
        end
    end

`ifdef FIFO_ERR_STICKY_EN
    logic overflow_r, underflow_r;

    // Sticky error capture, cleared only by reset or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (flush) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= overflow_r  | (push & full & ~pop_ok_s);
            underflow_r <= underflow_r | (pop & empty);
        end
    end

    assign overflow  = overflow_r;
    assign underflow = underflow_r;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (wptr_r),
        .wdata (wdata),
        .raddr (rptr_r),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_fifo_flagged.sv
// Self-checking bench for fifo_flagged: directed vector table, sticky-flag sequence,
// and randomized traffic compared against a queue-based reference model.
module tb_fifo_flagged;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;
`ifdef FIFO_ERR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n, flush, push, pop;
    logic [WIDTH-1:0] wdata, rdata;
    logic             full, almost_full, empty, almost_empty, overflow, underflow;
    logic [2:0]       count;

    fifo_flagged #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .push(push), .wdata(wdata),
        .full(full), .almost_full(almost_full), .pop(pop), .rdata(rdata),
        .empty(empty), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: contents as a queue, error flags as plain bits.
    logic [WIDTH-1:0] mq[$];
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    typedef struct {
        bit         f, pu, po;
        logic [7:0] wd;
        int         cnt;
        logic [7:0] rd;
        bit         ae, af, fu, em;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit f, input bit pu, input bit po, input logic [7:0] wd);
        int  sz;
        bit  pop_ok, push_ok;
        sz = mq.size();
        if (f) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            pop_ok  = po && (sz > 0);
            push_ok = pu && ((sz < DEPTH) || pop_ok);
            if (pu && (sz == DEPTH) && !pop_ok) m_ovf = STICKY;
            if (po && (sz == 0)) m_unf = STICKY;
            if (pop_ok) void'(mq.pop_front());
            if (push_ok) mq.push_back(wd);
        end
    endtask

    task automatic check_model(input string tag);
        int sz;
        sz = mq.size();
        chk({tag, ".count"}, count, sz);
        chk({tag, ".empty"}, empty, (sz == 0));
        chk({tag, ".full"}, full, (sz == DEPTH));
        chk({tag, ".almost_empty"}, almost_empty, (sz <= AE));
        chk({tag, ".almost_full"}, almost_full, (sz >= AF));
        chk({tag, ".overflow"}, overflow, m_ovf);
        chk({tag, ".underflow"}, underflow, m_unf);
        if (sz > 0) chk({tag, ".rdata"}, rdata, mq[0]);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic step(input bit f, input bit pu, input bit po, input logic [7:0] wd);
        flush = f; push = pu; pop = po; wdata = wd;
        @(posedge clk);
        model_step(f, pu, po, wd);
        #1;
    endtask

    function automatic vec_t mk(bit f, bit pu, bit po, logic [7:0] wd, int cnt,
                                logic [7:0] rd, bit ae, bit af, bit fu, bit em);
        vec_t v;
        v.f = f; v.pu = pu; v.po = po; v.wd = wd; v.cnt = cnt;
        v.rd = rd; v.ae = ae; v.af = af; v.fu = fu; v.em = em;
        return v;
    endfunction

    initial begin
        // Expected state after each edge, starting from an empty FIFO.
        vt[0]  = mk(0, 1, 0, 8'hA1, 1, 8'hA1, 1, 0, 0, 0);
        vt[1]  = mk(0, 1, 0, 8'hA2, 2, 8'hA1, 0, 0, 0, 0);
        vt[2]  = mk(0, 1, 0, 8'hA3, 3, 8'hA1, 0, 1, 0, 0);
        vt[3]  = mk(0, 1, 0, 8'hA4, 4, 8'hA1, 0, 1, 1, 0);
        vt[4]  = mk(0, 1, 1, 8'hB0, 4, 8'hA2, 0, 1, 1, 0);
        vt[5]  = mk(0, 0, 1, 8'h00, 3, 8'hA3, 0, 1, 0, 0);
        vt[6]  = mk(0, 0, 1, 8'h00, 2, 8'hA4, 0, 0, 0, 0);
        vt[7]  = mk(0, 0, 1, 8'h00, 1, 8'hB0, 1, 0, 0, 0);
        vt[8]  = mk(0, 0, 1, 8'h00, 0, 8'h00, 1, 0, 0, 1);
        vt[9]  = mk(0, 1, 1, 8'hC5, 1, 8'hC5, 1, 0, 0, 0);
        vt[10] = mk(0, 1, 0, 8'h12, 2, 8'hC5, 0, 0, 0, 0);
        vt[11] = mk(0, 1, 0, 8'h13, 3, 8'hC5, 0, 1, 0, 0);
        vt[12] = mk(1, 1, 0, 8'hFF, 0, 8'h00, 1, 0, 0, 1);
        vt[13] = mk(0, 1, 0, 8'h11, 1, 8'h11, 1, 0, 0, 0);
        vt[14] = mk(0, 0, 1, 8'h00, 0, 8'h00, 1, 0, 0, 1);

        // Reset with active inputs must still yield the idle state.
        rst_n = 1'b0; flush = 1'b0; push = 1'b1; pop = 1'b1; wdata = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.count", count, 0);
        chk("reset.empty", empty, 1);
        chk("reset.full", full, 0);
        chk("reset.almost_empty", almost_empty, 1);
        chk("reset.almost_full", almost_full, 0);
        chk("reset.overflow", overflow, 0);
        chk("reset.underflow", underflow, 0);
        push = 1'b0; pop = 1'b0;
        rst_n = 1'b1;
        step(0, 0, 0, 8'h00);
        check_model("idle");

        for (int i = 0; i < 15; i++) begin
            step(vt[i].f, vt[i].pu, vt[i].po, vt[i].wd);
            check_model($sformatf("vec%0d.model", i));
            chk($sformatf("vec%0d.count", i), count, vt[i].cnt);
            chk($sformatf("vec%0d.almost_empty", i), almost_empty, vt[i].ae);
            chk($sformatf("vec%0d.almost_full", i), almost_full, vt[i].af);
            chk($sformatf("vec%0d.full", i), full, vt[i].fu);
            chk($sformatf("vec%0d.empty", i), empty, vt[i].em);
            if (!vt[i].em) chk($sformatf("vec%0d.rdata", i), rdata, vt[i].rd);
        end
        chk("vec_end.overflow", overflow, 0);
        chk("vec_end.underflow", underflow, 0);

        // Overflow: push into full FIFO without pop must not disturb contents.
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'hD1 + 8'(i));
        step(0, 1, 0, 8'hEE);
        check_model("ovf");
        chk("ovf.flag", overflow, STICKY);
        chk("ovf.count", count, 4);
        chk("ovf.rdata", rdata, 8'hD1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf.drain%0d", i), rdata, 8'hD1 + 8'(i));
            step(0, 0, 1, 8'h00);
            check_model("ovf.drain");
        end
        step(0, 0, 1, 8'h00);
        check_model("unf");
        chk("unf.flag", underflow, STICKY);
        chk("unf.count", count, 0);
        step(0, 0, 0, 8'h00);
        chk("hold.overflow", overflow, STICKY);
        chk("hold.underflow", underflow, STICKY);
        step(1, 0, 0, 8'h00);
        chk("flush.overflow", overflow, 0);
        chk("flush.underflow", underflow, 0);
        check_model("flush");

        // Randomized traffic in fill-biased and drain-biased phases.
        for (int i = 0; i < 600; i++) begin
            bit f, pu, po;
            int bias;
            bias = ((i / 40) % 2 == 0) ? 75 : 30;
            f  = ($urandom_range(0, 39) == 0);
            pu = ($urandom_range(0, 99) < bias);
            po = ($urandom_range(0, 99) < (100 - bias));
            step(f, pu, po, 8'($urandom));
            check_model("rand");
        end

        // Asynchronous reset away from any edge clears state immediately.
        push = 1'b1; pop = 1'b0; flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        check_model("async_reset");
        push = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
